// File: rtl/bus_pkg.sv
// Shared types for the round-robin memory bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    typedef enum logic {
        BUS_READ  = 1'b0,
        BUS_WRITE = 1'b1
    } bus_rw_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int unsigned idx;

    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % 32'(N);
            if (!any_req && req[idx[IDX_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-core round-robin arbiter in front of the single-port gpiomem RAM,
// with burst ownership, bounded hold under contention and per-core read-valid pulses.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_HOLD  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_request,
    output logic [NUM_CORES-1:0]          core_grant,
    input  logic [NUM_CORES-1:0]          core_rw,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_address,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic [ADDR_W-1:0]             ram_address,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_rw,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(NUM_CORES)-1:0]  owner
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     ptr_next;
    logic [IDX_W-1:0]     sel_ptr;
    logic [IDX_W-1:0]     sel_winner;
    logic                 sel_any;
    logic                 grant_load;
    logic                 owner_req;
    logic                 others_req;
    logic [NUM_CORES-1:0] owner_mask;
    logic [CNT_W-1:0]     hold_cnt_q;
    logic                 rd_v1, rd_v2;
    logic [IDX_W-1:0]     rd_o1, rd_o2;

    assign owner_mask = NUM_CORES'(1) << owner;
    assign owner_req  = core_request[owner];
    assign others_req = |(core_request & ~owner_mask);
    assign ptr_next   = (owner == IDX_W'(NUM_CORES - 1)) ? '0 : owner + IDX_W'(1);

    rr_select #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req     (core_request),
        .ptr     (sel_ptr),
        .winner  (sel_winner),
        .any_req (sel_any)
    );

    // HANDOFF selects with owner+1 directly so the new owner is chosen in the
    // same cycle rr_ptr is updated; a preempted owner thus ranks last.
    always_comb begin
        state_d    = state_q;
        sel_ptr    = rr_ptr_q;
        grant_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d    = OWN;
                    grant_load = 1'b1;
                end
            end
            OWN: begin
                if (!owner_req || (hold_cnt_q >= CNT_W'(MAX_HOLD - 1) && others_req))
                    state_d = HANDOFF;
            end
            HANDOFF: begin
                sel_ptr = ptr_next;
                if (sel_any) begin
                    state_d    = OWN;
                    grant_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            core_grant  <= '0;
            owner       <= '0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            ram_address <= '0;
            ram_wdata   <= '0;
            ram_rw      <= 1'b0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_o1       <= '0;
            rd_o2       <= '0;
            core_rvalid <= '0;
            core_rdata  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_load) begin
                core_grant <= NUM_CORES'(1) << sel_winner;
                owner      <= sel_winner;
            end else if (state_d != OWN) begin
                core_grant <= '0;
            end

            if (state_q == OWN) begin
                if (hold_cnt_q != CNT_W'(MAX_HOLD))
                    hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                ram_address <= core_address[owner*ADDR_W +: ADDR_W];
                ram_wdata   <= core_wdata[owner*DATA_W +: DATA_W];
                ram_rw      <= owner_req & core_rw[owner];
            end else begin
                hold_cnt_q <= '0;
                ram_rw     <= 1'b0;
            end

            if (state_q == HANDOFF)
                rr_ptr_q <= ptr_next;

            // Stage 1 aligns with the RAM address, stage 2 with RAM data out.
            rd_v1 <= (state_q == OWN) && owner_req && (bus_rw_t'(core_rw[owner]) == BUS_READ);
            rd_o1 <= owner;
            rd_v2 <= rd_v1;
            rd_o2 <= rd_o1;
            core_rvalid <= rd_v2 ? (NUM_CORES'(1) << rd_o2) : '0;
            if (rd_v2)
                core_rdata <= ram_rdata;
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(core_grant));

endmodule
